// File: rtl/ccff_loader.sv
// ccff_loader: streams a word-wide configuration bitstream into a serial
// configuration flip-flop chain, LSB first, after holding the chain in reset.
// Optional loopback check on ccff_tail: define CCFF_LOADER_TAIL_CHECK_EN.
module ccff_loader #(
    parameter int unsigned CHAIN_LEN  = 1024,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ccff_tail,
    output logic              ccff_head,
    output logic              shift_en,
    output logic              chain_reset,
    output logic              busy,
`ifdef CCFF_LOADER_TAIL_CHECK_EN
    output logic              done,
    output logic              tail_err
`else
    output logic              done
`endif
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);
    localparam logic [7:0]        LAST_RST  = 8'(RST_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CRST  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WCNT_W-1:0] wbit_cnt;
    logic [7:0]        rst_cnt;

    // Sequencer: chain reset, word handshake, bit shifting and termination
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            wbit_cnt <= '0;
            rst_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_CRST;
                        bit_cnt <= '0;
                        rst_cnt <= '0;
                    end
                end
                S_CRST: begin
                    if (rst_cnt == LAST_RST) begin
                        state <= S_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        shreg    <= in_data;
                        wbit_cnt <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg    <= shreg >> 1;
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    wbit_cnt <= wbit_cnt + WCNT_W'(1);
                    // Chain-full takes priority so a partially used word is dropped
                    if (bit_cnt == LAST_BIT) begin
                        state <= S_DONE;
                    end else if (wbit_cnt == LAST_WBIT) begin
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode straight from state so reset forces every output low
    always_comb begin
        shift_en    = (state == S_SHIFT);
        chain_reset = (state == S_CRST);
        in_ready    = (state == S_WAIT);
        busy        = (state == S_CRST) || (state == S_WAIT) || (state == S_SHIFT);
        done        = (state == S_DONE);
        ccff_head   = (state == S_SHIFT) & shreg[0];
    end

`ifdef CCFF_LOADER_TAIL_CHECK_EN
    // Loopback check: a freshly reset chain must only ever shift out zeros
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            tail_err <= 1'b0;
        end else if ((state == S_IDLE || state == S_DONE) && start) begin
            tail_err <= 1'b0;
        end else if (state == S_SHIFT && ccff_tail) begin
            tail_err <= 1'b1;
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: two instances (64-bit and 40-bit chains,
// 32-bit words) driven from a table of load scenarios plus hand sequences.
module tb_ccff_loader;

    logic        prog_clk = 1'b0;
    logic        prog_reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        ccff_tail = 1'b0;

    logic rdy_a, hd_a, se_a, cr_a, bs_a, dn_a;
    logic rdy_b, hd_b, se_b, cr_b, bs_b, dn_b;
`ifdef CCFF_LOADER_TAIL_CHECK_EN
    logic te_a, te_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_loader #(.CHAIN_LEN(64), .WORD_W(32), .RST_CYCLES(4)) dut_a (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .start       (start_a),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (rdy_a),
        .ccff_tail   (ccff_tail),
        .ccff_head   (hd_a),
        .shift_en    (se_a),
        .chain_reset (cr_a),
        .busy        (bs_a),
`ifdef CCFF_LOADER_TAIL_CHECK_EN
        .done        (dn_a),
        .tail_err    (te_a)
`else
        .done        (dn_a)
`endif
    );

    ccff_loader #(.CHAIN_LEN(40), .WORD_W(32), .RST_CYCLES(4)) dut_b (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .start       (start_b),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (rdy_b),
        .ccff_tail   (ccff_tail),
        .ccff_head   (hd_b),
        .shift_en    (se_b),
        .chain_reset (cr_b),
        .busy        (bs_b),
`ifdef CCFF_LOADER_TAIL_CHECK_EN
        .done        (dn_b),
        .tail_err    (te_b)
`else
        .done        (dn_b)
`endif
    );

    typedef struct {
        int          sel;         // 0: 64-bit chain, 1: 40-bit chain
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;         // extra WAIT cycles before word 1
        int          exp_shifts;
        int          start_at;    // shift index at which start is pulsed, -1 none
        int          tail_at;     // shift index at which ccff_tail=1, -1 none
        logic        exp_tail;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample(input int sel, output logic cr, output logic se, output logic hd,
                          output logic rdy, output logic dn, output logic bs, output logic te);
        te = 1'b0;
        if (sel == 0) begin
            cr = cr_a; se = se_a; hd = hd_a; rdy = rdy_a; dn = dn_a; bs = bs_a;
`ifdef CCFF_LOADER_TAIL_CHECK_EN
            te = te_a;
`endif
        end else begin
            cr = cr_b; se = se_b; hd = hd_b; rdy = rdy_b; dn = dn_b; bs = bs_b;
`ifdef CCFF_LOADER_TAIL_CHECK_EN
            te = te_b;
`endif
        end
    endtask

    task automatic check_all_low(input string tag);
        chk({tag, "_a_outs"}, {58'd0, rdy_a, hd_a, se_a, cr_a, bs_a, dn_a}, 64'd0);
        chk({tag, "_b_outs"}, {58'd0, rdy_b, hd_b, se_b, cr_b, bs_b, dn_b}, 64'd0);
`ifdef CCFF_LOADER_TAIL_CHECK_EN
        chk({tag, "_tail_err"}, {62'd0, te_a, te_b}, 64'd0);
`endif
    endtask

    // One complete load on the selected instance, checked against the model
    task automatic run_load(input vec_t v, input string tag);
        int ncr = 0, nsh = 0, nwait = 0, idx = 0, gapc = 0;
        logic [63:0] got = '0;
        logic [63:0] expv;
        logic [63:0] mask;
        bit hs_prev = 0, se_prev = 0, dec_bad = 0, lat_bad = 0, extra_wait = 0;
        bit done_ok = 0, fin = 0, tail_pend = 0;
        logic cr, se, hd, rdy, dn, bs, te;

        @(negedge prog_clk);
        if (v.sel == 0) start_a = 1'b1; else start_b = 1'b1;
        for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
            @(negedge prog_clk);
            start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; ccff_tail = 1'b0;
            sample(v.sel, cr, se, hd, rdy, dn, bs, te);
            if (tail_pend) begin
                chk({tag, "_tail_err_set"}, {63'd0, te}, 64'd1);
                tail_pend = 0;
            end
            if ((se && cr) || (!se && hd)) dec_bad = 1;
            if (hs_prev && !se) lat_bad = 1;
            hs_prev = 0;
            if (cr) ncr++;
            if (se) begin
                if (nsh < 64) got[nsh] = hd;
                if (nsh == v.start_at) begin
                    if (v.sel == 0) start_a = 1'b1; else start_b = 1'b1;
                end
                if (nsh == v.tail_at) begin
                    ccff_tail = 1'b1;
`ifdef CCFF_LOADER_TAIL_CHECK_EN
                    chk({tag, "_tail_err_pre"}, {63'd0, te}, 64'd0);
                    tail_pend = 1;
`endif
                end
                nsh++;
            end
            if (rdy) begin
                if (idx == 1) nwait++;
                if (idx >= 2) begin
                    extra_wait = 1;
                end else if (idx == 0 || gapc >= v.gap) begin
                    in_valid = 1'b1;
                    in_data  = (idx == 0) ? v.w0 : v.w1;
                    idx++;
                    hs_prev = 1;
                end else begin
                    gapc++;
                end
            end
            if (dn) begin
                done_ok = se_prev;
                fin = 1;
            end
            se_prev = se;
        end

        mask = (v.exp_shifts >= 64) ? '1 : ((64'd1 << v.exp_shifts) - 64'd1);
        expv = {v.w1, v.w0} & mask;
        chk({tag, "_finished"}, {63'd0, fin}, 64'd1);
        chk({tag, "_crst_cycles"}, 64'(ncr), 64'd4);
        chk({tag, "_shift_count"}, 64'(nsh), 64'(v.exp_shifts));
        chk({tag, "_head_bits"}, got, expv);
        chk({tag, "_wait_cycles"}, 64'(nwait), 64'(v.gap + 1));
        chk({tag, "_done_after_last"}, {63'd0, done_ok}, 64'd1);
        chk({tag, "_busy_done"}, {62'd0, bs, dn}, 64'd1);
        chk({tag, "_decode"}, {62'd0, dec_bad, extra_wait}, 64'd0);
        chk({tag, "_latency"}, {63'd0, lat_bad}, 64'd0);
`ifdef CCFF_LOADER_TAIL_CHECK_EN
        chk({tag, "_tail_err_end"}, {63'd0, te}, {63'd0, v.exp_tail});
`endif
    endtask

    initial begin
        vec_t tbl[5];
        vec_t tv;
        int nsh;

        tbl[0] = '{0, 32'hDEADBEEF, 32'h12345678, 0,  64, -1, -1, 1'b0};
        tbl[1] = '{1, 32'hDEADBEEF, 32'h12345678, 0,  40, -1, -1, 1'b0};
        tbl[2] = '{0, 32'hA5A5F00F, 32'h0F0F3CC3, 10, 64, -1, -1, 1'b0};
        tbl[3] = '{0, 32'hFFFFFFFF, 32'h00000001, 0,  64, 10, -1, 1'b0};
        tbl[4] = '{1, 32'h00000000, 32'hFFFFFFFF, 3,  40, 35, -1, 1'b0};

        #1;
        check_all_low("reset");
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        repeat (3) @(negedge prog_clk);
        check_all_low("idle_after_reset");

        for (int i = 0; i < 5; i++) begin
            run_load(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset pulsed mid-load after 17 shifts
        @(negedge prog_clk);
        start_a = 1'b1;
        nsh = 0;
        for (int cyc = 0; cyc < 200 && nsh < 17; cyc++) begin
            @(negedge prog_clk);
            start_a = 1'b0; in_valid = 1'b0;
            if (se_a) nsh++;
            if (rdy_a) begin
                in_valid = 1'b1;
                in_data  = 32'hCAFEF00D;
            end
        end
        chk("midreset_reached17", 64'(nsh), 64'd17);
        in_valid = 1'b0;
        prog_reset_n = 1'b0;
        #1;
        check_all_low("midreset");
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        repeat (6) @(negedge prog_clk);
        check_all_low("after_midreset");
        run_load(tbl[0], "post_reset");

`ifdef CCFF_LOADER_TAIL_CHECK_EN
        tv = '{0, 32'h13579BDF, 32'h2468ACE0, 0, 64, -1, 4, 1'b1};
        run_load(tv, "tail");
        run_load(tbl[0], "tail_cleared");
`else
        tv = tbl[1];
        run_load(tv, "repeat_b");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 1024: number of configuration flip-flops in the target ccff chain; legal range 1..65535.
REQ-002 Parameter WORD_W, default 32: bitstream word width; legal range 1..64.
REQ-003 Parameter RST_CYCLES, default 4: number of cycles the chain reset is held; legal range 1..255.
REQ-004 prog_clk  in  1  sole clock; all state changes occur on its rising edge.
REQ-005 prog_reset_n  in  1  asynchronous, active-low block reset.
REQ-006 start  in  1  one-cycle request to begin a load.
REQ-007 in_data  in  WORD_W  bitstream word.
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  loader accepts in_data this cycle.
REQ-010 ccff_tail  in  1  chain output, used for the loopback check.
REQ-011 ccff_head  out  1  serial configuration bit to the chain.
REQ-012 shift_en  out  1  chain shift enable; the chain advances one bit per cycle in which it is 1.
REQ-013 chain_reset  out  1  active-high reset to the chain.
REQ-014 busy  out  1  load in progress.
REQ-015 done  out  1  load complete, held until the next start.
REQ-016 tail_err  out  1  loopback mismatch; present only under REQ-033.

Function
REQ-017 FSM states: IDLE, CRST, WAIT, SHIFT, DONE.
- IDLE or DONE, start=1: go to CRST; clear done, bit counter and tail_err.
- CRST: chain_reset=1 for exactly RST_CYCLES cycles, then go to WAIT.
REQ-018 WAIT: in_ready=1.
- in_valid=1 captures in_data into the shift register and goes to SHIFT.
- in_valid=0 stays in WAIT indefinitely.
REQ-019 SHIFT: one bit per cycle.
- ccff_head = current shift-register LSB; shift_en=1.
- Shift register shifts right; bit counter increments.
- in_ready=0 throughout SHIFT.
REQ-020 After WORD_W bits of a word, go to WAIT if the bit counter < CHAIN_LEN; otherwise go to DONE.
REQ-021 When the bit counter reaches CHAIN_LEN mid-word, go to DONE immediately; the remaining bits of that word are discarded and never drive shift_en.
REQ-022 Total shift_en=1 cycles per load SHALL equal exactly CHAIN_LEN.
REQ-023 Bit ordering: word LSB first; the first word's bit 0 ends up deepest in the chain.
REQ-024 DONE: done=1, busy=0, shift_en=0; remain in DONE until start.
REQ-025 busy=1 in CRST, WAIT and SHIFT; busy=0 otherwise.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 Output decode: ccff_head=0 whenever shift_en=0; shift_en and chain_reset SHALL never both be 1.
REQ-028 Latency: shift_en rises on the cycle after the WAIT handshake; no idle cycles between bits within a word; exactly one WAIT cycle between words when in_valid is held 1.
REQ-029 Bit counter width = clog2(CHAIN_LEN+1); it SHALL never wrap.

Reset
REQ-030 prog_reset_n=0 asynchronously forces state IDLE, in_ready=0, ccff_head=0, shift_en=0, chain_reset=0, busy=0, done=0, tail_err=0, and clears the counters and the shift register.
REQ-031 Reset asserted mid-load abandons the load; after release the block waits in IDLE for start, with no shift_en pulse.
REQ-032 Deassertion of prog_reset_n is taken synchronously to prog_clk by the block's registers; the first state change occurs on a start sampled after release.

Configuration
REQ-033 Macro CCFF_LOADER_TAIL_CHECK_EN.
- Defined: in every shift_en=1 cycle, ccff_tail is sampled; since the chain was reset in CRST it must read 0. Any 1 sets tail_err sticky until the next start or reset.
- Undefined: the tail_err port and the checking logic are absent, and ccff_tail is unused.

Verification
REQ-034 CHAIN_LEN=64, WORD_W=32, two words 0xDEADBEEF and 0x12345678 -> 4 chain_reset cycles, exactly 64 shift_en cycles, ccff_head sequence = LSB-first bits of both words, done=1.
REQ-035 CHAIN_LEN=40, WORD_W=32, two words -> 40 shift_en cycles; upper 24 bits of word 2 never appear; done=1 on the cycle after the 40th shift.
REQ-036 in_valid withheld 10 cycles between words -> block holds in WAIT, shift_en=0 and in_ready=1 for those cycles; bit order unchanged.
REQ-037 prog_reset_n pulsed low after 17 shifts -> all outputs 0 immediately; a new start performs a full, correct CHAIN_LEN load.
REQ-038 start pulsed during SHIFT -> no effect on shift count or done timing.
REQ-039 With CCFF_LOADER_TAIL_CHECK_EN, ccff_tail forced 1 on shift cycle 5 -> tail_err=1 from the next cycle until the next start.
